// File: rtl/switch_debounce_sync_pkg.sv
// Shared constants and helpers for the slide-switch conditioning path.
// Board timing gives a 10 ms debounce window; benches use a short window.
package switch_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CYCLES     = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SW_WIDTH            = 4;
  localparam int SIM_DEBOUNCE_CYCLES = 8;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  function automatic edge_e edge_kind(input logic prev_lvl, input logic next_lvl);
    if (prev_lvl == next_lvl) return EDGE_NONE;
    return next_lvl ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/switch_debounce_sync_if.sv
// Switch bundle between the pin side (master) and the conditioner (slave).
interface switch_debounce_sync_if #(
  parameter int WIDTH = switch_pkg::SW_WIDTH
) ();

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;
  logic             all_settled;

  modport master (
    output sw_raw,
    input  sw_stable, sw_rise, sw_fall, sw_changed, all_settled
  );

  modport slave (
    input  sw_raw,
    output sw_stable, sw_rise, sw_fall, sw_changed, all_settled
  );

endinterface

// File: rtl/switch_debounce_sync_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, stable level
// and registered rise/fall strobes coincident with the level update.
module debounce_bit
  import switch_pkg::edge_e;
  import switch_pkg::edge_kind;
  import switch_pkg::EDGE_RISE;
  import switch_pkg::EDGE_FALL;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic match_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  edge_e            edge_w;

  assign edge_w = edge_kind(stable_q, s2_q);

  // Any matching cycle clears the count, so a bounce restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        rise_d   = (edge_w == EDGE_RISE);
        fall_d   = (edge_w == EDGE_FALL);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign match_o  = (s2_q == stable_q);

endmodule

// File: rtl/switch_debounce_sync.sv
// Conditions the board slide switches into clean levels plus edge strobes;
// every output is driven from flops, never directly from the pins.
module switch_debounce_sync
  import switch_pkg::SW_WIDTH;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = switch_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  switch_debounce_sync_if.slave bus
);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] match_w;
  logic             all_settled_q, all_settled_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (bus.sw_raw[i]),
      .stable_o (stable_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i]),
      .match_o  (match_w[i])
    );
  end

  assign all_settled_d = &match_w;

  // Settled flag idles high out of reset: nothing is pending yet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_settled_q <= 1'b1;
    end else begin
      all_settled_q <= all_settled_d;
    end
  end

  assign bus.sw_stable   = stable_w;
  assign bus.sw_rise     = rise_w;
  assign bus.sw_fall     = fall_w;
  assign bus.sw_changed  = |(rise_w | fall_w);
  assign bus.all_settled = all_settled_q;

endmodule

// File: doc/switch_debounce_sync.md
Name: switch_debounce_sync

Overview:
- Input conditioning stage between the EGO1 board slide switches and the combinational logic-function blocks that drive the LEDs.
- Synchronises each asynchronous switch into the clk domain, then debounces it with a per-bit stability counter.
- Outputs a clean level vector, plus one-cycle rise/fall/change strobes for downstream sequential consumers.

Parameters:
- WIDTH, 4: number of switch bits conditioned.
- DEBOUNCE_CYCLES, 1000000: consecutive mismatching cycles before a bit is accepted (10 ms at 100 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): per-bit counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, 100 MHz on EGO1.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- sw_raw  in  WIDTH  asynchronous switch levels straight from pins.
- sw_stable  out  WIDTH  debounced levels; feed a/b/c/d of the logic block.
- sw_rise  out  WIDTH  one-cycle pulse per bit on debounced 0->1.
- sw_fall  out  WIDTH  one-cycle pulse per bit on debounced 1->0.
- sw_changed  out  1  one-cycle pulse; OR of sw_rise and sw_fall.
- all_settled  out  1  high when every synchronised bit equals its stable bit.

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - Sync flops, counters, sw_stable, sw_rise, sw_fall and sw_changed all clear to 0.
  - all_settled resets to 1.
  - Any debounce in progress is discarded.
- Synchroniser: two flops per bit, s1<=sw_raw, s2<=s1. No combinational path from sw_raw to any output.
- Per-bit debounce, evaluated at each edge:
  - s2==stable: counter<=0.
  - s2!=stable and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable<=s2, counter<=0, and the matching rise or fall pulse is asserted for exactly that next cycle.
- A mismatch broken by even one matching cycle restarts the count from 0 (bounce rejection).
- Latency: let edge k be the first edge sampling a new sw_raw level that then holds. sw_stable updates at edge k+DEBOUNCE_CYCLES+1, and the pulse is high during the following cycle.
- Pulses are registered and coincident with the sw_stable update; each lasts exactly one cycle. rise and fall never assert together on one bit.
- Simultaneous transitions on several bits produce pulses on all of them in the same cycle. sw_changed is then a single one-cycle pulse, not one per bit.
- all_settled is registered: it is 0 in any cycle where some bit has s2!=stable.
- Switch already on at reset release: treated as a normal 0->1 transition; the rise pulse is emitted.
- Counters never wrap; the maximum value is DEBOUNCE_CYCLES-1.
- Bits are fully independent. Separate counters, no shared arbitration.

Decomposition:
- Package switch_pkg holds:
  - CLK_HZ=100_000_000, DEBOUNCE_MS=10, and DEBOUNCE_CYCLES=CLK_HZ/1000*DEBOUNCE_MS.
  - SW_WIDTH=4.
  - SIM_DEBOUNCE_CYCLES=8 for benches.
- Sub-module debounce_bit: synchroniser, counter, stable flop and rise/fall pulses for one bit. It is instantiated WIDTH times via generate.
- The top level ORs the pulses into sw_changed and ANDs the per-bit match flags into all_settled.

Test Plan (DEBOUNCE_CYCLES=8):
1. Reset: sw_raw=4'hF, rst_n=0 for 3 edges -> sw_stable=0, pulses=0, all_settled=1. After release (edge k) -> sw_stable=4'hF at edge k+9, sw_rise=4'hF for one cycle, sw_changed one cycle.
2. Clean press: sw_raw 0000->0001, first sampled at edge k -> all_settled=0 from k+2 to k+9. sw_stable=0001 at k+9; sw_rise=0001 and sw_changed=1 for exactly one cycle; all_settled=1 after.
3. Bounce: sw_raw[1] toggles every 3 cycles for 30 cycles, then holds 1 from edge k -> no change on sw_stable or pulses during the bounce. Single sw_rise=0010 at k+9.
4. Simultaneous: sw_raw 0000->1010 at one edge -> sw_stable=1010 on one edge, sw_rise=1010, exactly one sw_changed pulse.
5. Release: sw_stable=0001, then sw_raw=0000 held -> sw_fall=0001 for one cycle, sw_rise=0000, sw_stable=0000 at k+9.
6. Reset mid-debounce: assert rst_n=0 for one edge after 5 mismatch cycles, sw_raw held 1 -> outputs 0, count lost. sw_stable rises at r+9, where r is the first edge after release.
